// File: rtl/sram_rr_ctrl_pkg.sv
// Shared types and SRAM pin encodings for the two-requester SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] CS_SEL   = 2'd0;
  localparam logic [1:0] CS_DESEL = 2'd1;
  localparam logic [1:0] WE_WR    = 2'd0;
  localparam logic [1:0] WE_RD    = 2'd1;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 4;

endpackage

// File: rtl/sram_rr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-winner pointer
// updated on accept. Pointer resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_rr_ctrl.sv
// Round-robin controller for the 16x4 async SRAM macro: one transaction per
// 4 cycles (IDLE/SETUP/ACCESS/DONE), response pulse 3 cycles after acceptance.
module sram_rr_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter bit RD_INV = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic [1:0]    mem_we,
  output logic [1:0]    mem_cs,
  input  logic [DW-1:0] mem_o
);

  state_t        state_q, state_d;
  logic          we_q;
  logic          id_q;
  logic [AW-1:0] mem_a_q;
  logic [DW-1:0] mem_d_q;
  logic [DW-1:0] rdata_q;

  logic          idle;
  logic [1:0]    req_vec;
  logic [1:0]    gnt;
  logic          accept;
  logic          rsp_live;

  assign idle    = (state_q == IDLE) && !rst;
  assign req_vec = {req1_valid, req0_valid};
  assign accept  = idle && (req_vec != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .accept (accept),
    .gnt    (gnt)
  );

  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/data registers load only on the edge into SETUP, so they are
  // frozen for the whole selected window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      mem_a_q <= '0;
      mem_d_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q    <= gnt[1];
        we_q    <= gnt[1] ? req1_we    : req0_we;
        mem_a_q <= gnt[1] ? req1_addr  : req0_addr;
        mem_d_q <= gnt[1] ? req1_wdata : req0_wdata;
      end
      if ((state_q == ACCESS) && !we_q) begin
        rdata_q <= RD_INV ? ~mem_o : mem_o;
      end
    end
  end

  assign mem_a  = mem_a_q;
  assign mem_d  = mem_d_q;
  assign mem_cs = (state_q == ACCESS) ? CS_SEL : CS_DESEL;
  assign mem_we = ((state_q == ACCESS) && we_q) ? WE_WR : WE_RD;

  assign rsp_live   = (state_q == DONE) && !rst;
  assign rsp0_valid = rsp_live && !id_q;
  assign rsp1_valid = rsp_live && id_q;
  assign rsp0_rdata = (rsp0_valid && !we_q) ? rdata_q : '0;
  assign rsp1_rdata = (rsp1_valid && !we_q) ? rdata_q : '0;

endmodule

// File: doc/sram_rr_ctrl.md
Name: sram_rr_ctrl

Overview:
Two-requester round-robin controller for the 16x4 asynchronous SRAM macro.
- SRAM control pins: active-low chip select, write-enable low = write, read data returned inverted.
- Accepts one read or write per transaction from either requester over a valid/ready handshake.
- Sequences address setup, strobe and hold cycles so the macro never sees address or data change while selected.
- Returns a one-cycle response pulse carrying non-inverted read data.

Parameters:
AW, 4, address width (SRAM depth 2**AW)
DW, 4, data width
RD_INV, 1, 1 = invert mem_o on capture to undo macro inversion; 0 = pass through

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a transaction
req0_ready  out  1  requester 0 transaction accepted this cycle when valid&&ready
req0_we  in  1  1 = write, 0 = read
req0_addr  in  AW  word address
req0_wdata  in  DW  write data
rsp0_valid  out  1  one-cycle completion pulse for requester 0
rsp0_rdata  out  DW  read data, qualified by rsp0_valid
req1_valid / req1_ready / req1_we / req1_addr / req1_wdata  same as requester 0, for requester 1
rsp1_valid / rsp1_rdata  same as requester 0, for requester 1
mem_a  out  AW  SRAM address
mem_d  out  DW  SRAM write data
mem_we  out  2  2'd0 = write, 2'd1 = read/inactive
mem_cs  out  2  2'd0 = selected, 2'd1 = deselected
mem_o  in  DW  SRAM read data (inverted by macro, Z when deselected)

Behaviour:
- Clock and reset: one clock domain, clk; reset is synchronous and active-high on rst.
- FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. Fixed 4 cycles per transaction, no pipelining.
- IDLE:
  - Grant is combinational from valid inputs and the round-robin pointer.
  - reqN_ready = 1 only for the granted requester; both ready = 0 in every other state.
  - On valid&&ready, register op, addr, wdata and requester id, then go to SETUP.
- SETUP (T+1): mem_a/mem_d driven from registered values; mem_cs=1, mem_we=1.
- ACCESS (T+2):
  - mem_cs=0; mem_we=0 for a write, 1 for a read.
  - A read registers mem_o (inverted when RD_INV=1) into the rdata register at the end of the cycle.
- DONE (T+3):
  - mem_cs=1, mem_we=1; mem_a/mem_d held.
  - rspN_valid=1 for the owning requester only.
  - rspN_rdata = captured data for a read, 0 for a write.
  - Next state is IDLE.
- Latency: acceptance to response = 3 cycles. Next acceptance earliest at T+4.
- Outside ACCESS, mem_cs=1 and mem_we=1 always. mem_a/mem_d change only on the SETUP entry edge, never while mem_cs=0.
- Round robin:
  - Pointer `last` updates on acceptance to the granted id.
  - With both valid, grant goes to the id != last. With one valid, grant goes to it regardless of last.
  - Reset value last=1, so requester 0 wins the first contention.
- Requester obligations (bench asserts):
  - valid stays high and addr/we/wdata stay stable until accepted.
  - No new valid is issued by a requester before its response. The controller does not enforce this; the requester guarantees it.
- No response backpressure; rsp pulses are never stalled.
- Reset values: state=IDLE, last=1, mem_a=0, mem_d=0, mem_cs=2'd1, mem_we=2'd1, both ready=0 during reset cycle, both rsp_valid=0, rdata regs=0.
- Reset mid-transaction: at the next edge mem_cs=1 and state=IDLE. The in-flight transaction is dropped with no response; a write aborted in ACCESS may or may not have updated the SRAM.
- Address wrap: addr 2**AW-1 and 0 are ordinary; no wrap logic.
- Simultaneous: a new valid on the non-owning requester during SETUP/ACCESS/DONE waits; it is arbitrated in the next IDLE.

Decomposition:
- Package sram_ctrl_pkg:
  - state_t enum {IDLE, SETUP, ACCESS, DONE}.
  - Constants CS_SEL=2'd0, CS_DESEL=2'd1, WE_WR=2'd0, WE_RD=2'd1.
  - Default AW/DW localparams.
- Sub-module rr_arb2:
  - Combinational 2-way round-robin grant plus registered last pointer.
  - Inputs: clk, rst, req[1:0], accept. Output: gnt[1:0] one-hot.
- Top holds the FSM, capture registers and memory drive.

Test Plan:
- After reset, req0 write addr 5 data 4'hA:
  - req0_ready=1 same cycle.
  - T+2: mem_cs=0, mem_we=0, mem_a=5, mem_d=A.
  - T+3: rsp0_valid=1, rsp0_rdata=0.
- req0 read addr 5 with behavioural SRAM model (returns ~stored=4'h5) -> T+2 mem_we=1, mem_cs=0; T+3 rsp0_rdata=4'hA.
- req0 and req1 valid simultaneously after reset, both reads -> req0 granted first.
  - req1 accepted at T+4, rsp1 at T+7.
  - Continuous contention alternates 0,1,0,1.
- Only req1 active, four back-to-back writes to addr 15,0,15,0 -> accepted every 4th cycle. mem_cs low exactly 1 cycle each; mem_a never changes while mem_cs=0.
- rst pulsed during ACCESS of a req1 read -> next cycle mem_cs=2'd1, no rsp1_valid ever. Then both valid -> req0 granted (last reset to 1).
- RD_INV=0 build, read addr 3 with model driving 4'h6 -> rsp_rdata=4'h6.
